// File: rtl/axil_rd_arbiter_if.sv
// AXI4-Lite read address / read data channel bundle.
// The arbiter connects through the master modport and the downstream read stage through the slave modport.
interface axil_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  modport master (
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter for two read requesters sharing one AXI4-Lite read channel.
// Only one read transaction is outstanding at a time: IDLE -> ADDR -> DATA -> RESP -> IDLE.
module axil_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              s0_req_valid,
  output logic              s0_req_ready,
  input  logic [ADDR_W-1:0] s0_req_addr,
  input  logic [2:0]        s0_req_prot,
  input  logic              s1_req_valid,
  output logic              s1_req_ready,
  input  logic [ADDR_W-1:0] s1_req_addr,
  input  logic [2:0]        s1_req_prot,
  output logic              s0_rsp_valid,
  input  logic              s0_rsp_ready,
  output logic              s1_rsp_valid,
  input  logic              s1_rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  axil_rd_arbiter_if.master m_axil,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ptr;
  logic              r_grant;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arprot;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic w_any_req;
  logic w_pick;
  logic w_rsp_ready;

  // A lone requester always wins; the pointer only breaks ties.
  assign w_any_req   = s0_req_valid | s1_req_valid;
  assign w_pick      = (s0_req_valid & s1_req_valid) ? r_ptr : s1_req_valid;
  assign w_rsp_ready = r_grant ? s1_rsp_ready : s0_rsp_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_state_nxt  = r_state;
    s0_req_ready = 1'b0;
    s1_req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = S_ADDR;
          s0_req_ready = ~w_pick;
          s1_req_ready = w_pick;
        end
      end
      S_ADDR: if (m_axil.ARREADY) w_state_nxt = S_DATA;
      S_DATA: if (m_axil.RVALID)  w_state_nxt = S_RESP;
      S_RESP: if (w_rsp_ready)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ptr    <= 1'b0;
      r_grant  <= 1'b0;
      r_araddr <= '0;
      r_arprot <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_pick;
            r_araddr <= w_pick ? s1_req_addr : s0_req_addr;
            r_arprot <= w_pick ? s1_req_prot : s0_req_prot;
          end
        end
        S_DATA: begin
          if (m_axil.RVALID) begin
            r_rdata <= m_axil.RDATA;
            r_rresp <= m_axil.RRESP;
          end
        end
        S_RESP: begin
          // The requester just served loses the next tie.
          if (w_rsp_ready) r_ptr <= ~r_grant;
        end
        default: ;
      endcase
    end
  end

  assign m_axil.ARVALID = (r_state == S_ADDR);
  assign m_axil.RREADY  = (r_state == S_DATA);
  assign m_axil.ARADDR  = r_araddr;
  assign m_axil.ARPROT  = r_arprot;

  assign s0_rsp_valid = (r_state == S_RESP) & ~r_grant;
  assign s1_rsp_valid = (r_state == S_RESP) &  r_grant;
  assign rsp_data     = r_rdata;
  assign rsp_resp     = r_rresp;
  assign busy         = (r_state != S_IDLE);
  assign grant        = r_grant;

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Self-checking bench for axil_rd_arbiter: directed vector table, asynchronous reset
// abort, then random traffic checked against a round-robin reference model.
module tb_axil_rd_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic        s0_req_valid, s1_req_valid;
  logic        s0_req_ready, s1_req_ready;
  logic [31:0] s0_req_addr, s1_req_addr;
  logic [2:0]  s0_req_prot, s1_req_prot;
  logic        s0_rsp_valid, s1_rsp_valid;
  logic        s0_rsp_ready, s1_rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic        grant;

  axil_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .s0_req_valid (s0_req_valid),
    .s0_req_ready (s0_req_ready),
    .s0_req_addr  (s0_req_addr),
    .s0_req_prot  (s0_req_prot),
    .s1_req_valid (s1_req_valid),
    .s1_req_ready (s1_req_ready),
    .s1_req_addr  (s1_req_addr),
    .s1_req_prot  (s1_req_prot),
    .s0_rsp_valid (s0_rsp_valid),
    .s0_rsp_ready (s0_rsp_ready),
    .s1_rsp_valid (s1_rsp_valid),
    .s1_rsp_ready (s1_rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_resp     (rsp_resp),
    .m_axil       (bus.master),
    .busy         (busy),
    .grant        (grant)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int   total = 0;
  int   bad   = 0;
  logic model_p;

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, a1;
    logic [2:0]  p0, p1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait, r_wait, rsp_wait;
    logic        exp_g;
    logic [31:0] exp_addr;
    logic [2:0]  exp_prot;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete read from request to response, with programmable stalls.
  task automatic run_txn(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [2:0] p0, input logic [2:0] p1, input logic [31:0] rdata,
                         input logic [1:0] rresp, input int ar_wait, input int r_wait, input int rsp_wait,
                         input logic exp_g, input logic [31:0] exp_addr, input logic [2:0] exp_prot,
                         input string tag);
    @(negedge ACLK);
    s0_req_valid = v0; s1_req_valid = v1;
    s0_req_addr  = a0; s1_req_addr  = a1;
    s0_req_prot  = p0; s1_req_prot  = p1;
    #1;
    check({tag, " idle busy"}, busy, 1'b0);
    check({tag, " s0_req_ready"}, s0_req_ready, !exp_g);
    check({tag, " s1_req_ready"}, s1_req_ready, exp_g);
    @(posedge ACLK);
    @(negedge ACLK);
    s0_req_valid = 1'b0; s1_req_valid = 1'b0;
    s0_req_addr  = $urandom; s1_req_addr = $urandom;
    s0_req_prot  = 3'($urandom); s1_req_prot = 3'($urandom);
    #1;
    check({tag, " arvalid"}, bus.ARVALID, 1'b1);
    check({tag, " araddr"}, bus.ARADDR, exp_addr);
    check({tag, " arprot"}, bus.ARPROT, exp_prot);
    check({tag, " grant"}, grant, exp_g);
    for (int k = 0; k < ar_wait; k++) begin
      bus.ARREADY = 1'b0;
      bus.RVALID  = 1'b1;
      bus.RDATA   = $urandom;
      @(posedge ACLK);
      @(negedge ACLK);
      check({tag, " arvalid held"}, bus.ARVALID, 1'b1);
      check({tag, " araddr held"}, bus.ARADDR, exp_addr);
    end
    bus.ARREADY = 1'b1;
    bus.RVALID  = 1'b1;
    bus.RDATA   = $urandom;
    @(posedge ACLK);
    @(negedge ACLK);
    bus.RVALID = 1'b0;
    #1;
    check({tag, " arvalid drop"}, bus.ARVALID, 1'b0);
    check({tag, " rready"}, bus.RREADY, 1'b1);
    for (int k = 0; k < r_wait; k++) begin
      @(posedge ACLK);
      @(negedge ACLK);
      check({tag, " rready held"}, bus.RREADY, 1'b1);
    end
    bus.RVALID = 1'b1;
    bus.RDATA  = rdata;
    bus.RRESP  = rresp;
    @(posedge ACLK);
    @(negedge ACLK);
    bus.RVALID  = 1'b0;
    bus.ARREADY = 1'b0;
    bus.RDATA   = $urandom;
    bus.RRESP   = 2'($urandom);
    #1;
    check({tag, " rready drop"}, bus.RREADY, 1'b0);
    check({tag, " s0_rsp_valid"}, s0_rsp_valid, !exp_g);
    check({tag, " s1_rsp_valid"}, s1_rsp_valid, exp_g);
    check({tag, " rsp_data"}, rsp_data, rdata);
    check({tag, " rsp_resp"}, rsp_resp, rresp);
    for (int k = 0; k < rsp_wait; k++) begin
      s0_req_valid = 1'b1; s1_req_valid = 1'b1;
      if (exp_g) s0_rsp_ready = 1'b1;
      else       s1_rsp_ready = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      #1;
      check({tag, " rsp_valid held"}, exp_g ? s1_rsp_valid : s0_rsp_valid, 1'b1);
      check({tag, " rsp_data held"}, rsp_data, rdata);
      check({tag, " no arvalid"}, bus.ARVALID, 1'b0);
      check({tag, " no req_ready"}, {s0_req_ready, s1_req_ready}, 2'b00);
    end
    s0_req_valid = 1'b0; s1_req_valid = 1'b0;
    s0_rsp_ready = !exp_g;
    s1_rsp_ready = exp_g;
    @(posedge ACLK);
    @(negedge ACLK);
    s0_rsp_ready = 1'b0; s1_rsp_ready = 1'b0;
    #1;
    check({tag, " back idle"}, busy, 1'b0);
    check({tag, " rsp_valid clear"}, {s0_rsp_valid, s1_rsp_valid}, 2'b00);
    check({tag, " grant kept"}, grant, exp_g);
    model_p = !exp_g;
  endtask

  initial begin
    ARESETn = 1'b0;
    s0_req_valid = 1'b0; s1_req_valid = 1'b0;
    s0_req_addr  = '0;   s1_req_addr  = '0;
    s0_req_prot  = '0;   s1_req_prot  = '0;
    s0_rsp_ready = 1'b0; s1_rsp_ready = 1'b0;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = '0;
    model_p = 1'b0;

    //              v0 v1 a0            a1            p0      p1      rdata         rresp  arw rw rspw g  exp_addr      exp_prot
    vecs[0]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0004, 3'b001, 3'b110, 32'h1111_1111, 2'b00, 0, 0, 0, 1'b0, 32'hFFFF_FFFF, 3'b001};
    vecs[1]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0004, 3'b001, 3'b110, 32'h2222_2222, 2'b00, 0, 0, 0, 1'b1, 32'h0000_0004, 3'b110};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0004, 3'b001, 3'b110, 32'h3333_3333, 2'b00, 0, 0, 0, 1'b0, 32'hFFFF_FFFF, 3'b001};
    vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0004, 3'b001, 3'b110, 32'h4444_4444, 2'b00, 0, 0, 0, 1'b1, 32'h0000_0004, 3'b110};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 3'b010, 3'b000, 32'hDEAD_BEEF, 2'b00, 0, 1, 0, 1'b0, 32'h0000_1000, 3'b010};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0000_0000, 3'b000, 3'b000, 32'hA5A5_A5A5, 2'b01, 5, 0, 0, 1'b0, 32'h0000_2000, 3'b000};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_3000, 3'b000, 3'b101, 32'h1234_5678, 2'b10, 0, 2, 0, 1'b1, 32'h0000_3000, 3'b101};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0040, 3'b000, 3'b011, 32'hCAFE_F00D, 2'b00, 1, 0, 4, 1'b1, 32'h0000_0040, 3'b011};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0050, 32'h0000_0000, 3'b000, 3'b000, 32'h0BAD_C0DE, 2'b11, 0, 0, 0, 1'b0, 32'h0000_0050, 3'b000};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0060, 32'h0000_0000, 3'b001, 3'b000, 32'h5555_AAAA, 2'b00, 0, 0, 0, 1'b0, 32'h0000_0060, 3'b001};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0070, 32'h0000_0080, 3'b100, 3'b111, 32'h7777_8888, 2'b00, 0, 0, 0, 1'b1, 32'h0000_0080, 3'b111};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0090, 32'hFFFF_FFFC, 3'b100, 3'b111, 32'h8765_4321, 2'b00, 2, 1, 1, 1'b0, 32'h0000_0090, 3'b100};

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset busy", busy, 1'b0);
    check("reset grant", grant, 1'b0);
    check("reset arvalid", bus.ARVALID, 1'b0);
    check("reset rready", bus.RREADY, 1'b0);
    check("reset araddr", bus.ARADDR, 32'h0);
    check("reset rsp_data", rsp_data, 32'h0);
    check("reset rsp_valid", {s0_rsp_valid, s1_rsp_valid}, 2'b00);
    ARESETn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1, vecs[i].p0, vecs[i].p1,
              vecs[i].rdata, vecs[i].rresp, vecs[i].ar_wait, vecs[i].r_wait, vecs[i].rsp_wait,
              vecs[i].exp_g, vecs[i].exp_addr, vecs[i].exp_prot, $sformatf("vec%0d", i));
    end

    // Abort an s1 read in DATA with an asynchronous reset, mid-cycle.
    @(negedge ACLK);
    s1_req_valid = 1'b1; s1_req_addr = 32'h0000_ABC0; s1_req_prot = 3'b111;
    @(posedge ACLK);
    @(negedge ACLK);
    s1_req_valid = 1'b0;
    bus.ARREADY  = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    bus.ARREADY = 1'b0;
    #1;
    check("abort in data", bus.RREADY, 1'b1);
    check("abort grant", grant, 1'b1);
    #1;
    ARESETn = 1'b0;
    #1;
    check("async rready", bus.RREADY, 1'b0);
    check("async busy", busy, 1'b0);
    check("async grant", grant, 1'b0);
    check("async araddr", bus.ARADDR, 32'h0);
    check("async arprot", bus.ARPROT, 3'b000);
    check("async rsp_data", rsp_data, 32'h0);
    check("async rsp_resp", rsp_resp, 2'b00);
    check("async arvalid", bus.ARVALID, 1'b0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    model_p = 1'b0;
    run_txn(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 3'b010, 3'b001, 32'hFACE_0001, 2'b00,
            0, 0, 0, 1'b0, 32'h0000_0100, 3'b010, "post-reset");

    // Random traffic against a round-robin reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  v;
      logic [31:0] a0, a1, rd;
      logic [2:0]  p0, p1;
      logic [1:0]  rr;
      logic        g;
      v  = 2'($urandom_range(1, 3));
      a0 = $urandom; a1 = $urandom; rd = $urandom;
      p0 = 3'($urandom); p1 = 3'($urandom); rr = 2'($urandom);
      g  = (v == 2'b11) ? model_p : v[1];
      run_txn(v[0], v[1], a0, a1, p0, p1, rd, rr,
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              g, g ? a1 : a0, g ? p1 : p0, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
